// File: rtl/uart_rx_param_if.sv
// Receiver-side bundle: the serial pin in, and the word handshake out to the sink.
// master = receiver, slave = word sink / line driver.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic                 uart_rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_err;
  logic                 frame_err;
  logic                 overrun;
  logic                 busy;

  modport master (
    input  uart_rx, rx_ready,
    output rx_data, rx_valid, parity_err, frame_err, overrun, busy
  );

  modport slave (
    output uart_rx, rx_ready,
    input  rx_data, rx_valid, parity_err, frame_err, overrun, busy
  );
endinterface

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-flop synchroniser, 3-sample majority vote around
// mid-bit, optional parity, 1/2 stop bits, valid/ready output with overrun pulse.
//
// state  | meaning
// IDLE   | waiting for a 1->0 edge on the synchronised line
// START  | start bit; a high vote means a glitch, go back to IDLE
// DATA   | shifting DATA_BITS voted bits in, LSB first
// PARITY | checking the parity bit against the received data
// STOP   | voting stop bit(s); leaves right after the last vote
module uart_rx_param #(
  parameter int CLK_DIV    = 434,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic            clk,
  input  logic            rst,
  uart_rx_param_if.master bus
);

  localparam int CW  = $clog2(CLK_DIV);
  localparam int MID = CLK_DIV / 2;
  localparam logic [CW-1:0] S_LO  = CW'(MID - 1);
  localparam logic [CW-1:0] S_MID = CW'(MID);
  localparam logic [CW-1:0] S_HI  = CW'(MID + 1);
  localparam logic [CW-1:0] S_END = CW'(CLK_DIV - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam logic          PODD = (PARITY_ODD != 0);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t               state_q, state_d;
  logic                 meta_q, rxs_q, rxs_prev_q;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic                 s0_q, s0_d, s1_q, s1_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 perr_q, perr_d, ferr_q, ferr_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 perr_o_q, perr_o_d, ferr_o_q, ferr_o_d;
  logic                 ovr_q, ovr_d;
  logic                 vote, at_vote, wrap, done;

  assign vote    = (s0_q & s1_q) | (s0_q & rxs_q) | (s1_q & rxs_q);
  assign at_vote = (cnt_q == S_HI);
  assign wrap    = (cnt_q == S_END);

  // Synchroniser and edge-history flops idle high so reset never looks like a start edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q     <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      meta_q     <= bus.uart_rx;
      rxs_q      <= meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  // State, bit timing, shift register and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      s0_q     <= 1'b1;
      s1_q     <= 1'b1;
      shift_q  <= '0;
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      perr_o_q <= 1'b0;
      ferr_o_q <= 1'b0;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      shift_q  <= shift_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      perr_o_q <= perr_o_d;
      ferr_o_q <= ferr_o_d;
      ovr_q    <= ovr_d;
    end
  end

  // Next-state: frame sequencing, voting, and word hand-off to the sink.
  always_comb begin
    state_d  = state_q;
    cnt_d    = wrap ? '0 : cnt_q + 1'b1;
    bit_d    = bit_q;
    s0_d     = (cnt_q == S_LO)  ? rxs_q : s0_q;
    s1_d     = (cnt_q == S_MID) ? rxs_q : s1_q;
    shift_d  = shift_q;
    perr_d   = perr_q;
    ferr_d   = ferr_q;
    data_d   = data_q;
    valid_d  = valid_q;
    perr_o_d = perr_o_q;
    ferr_o_d = ferr_o_q;
    ovr_d    = 1'b0;
    done     = 1'b0;

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rxs_prev_q && !rxs_q) begin
          state_d = START;
          bit_d   = '0;
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end
      end
      START: begin
        if (at_vote && vote) begin
          state_d = IDLE;
        end else if (wrap) begin
          state_d = DATA;
          bit_d   = '0;
        end
      end
      DATA: begin
        if (at_vote) shift_d = {vote, shift_q[DATA_BITS-1:1]};
        if (wrap) begin
          if (bit_q == LAST_DATA) begin
            bit_d   = '0;
            state_d = (PARITY_EN != 0) ? PARITY : STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      PARITY: begin
        if (at_vote) perr_d = (^shift_q) ^ vote ^ PODD;
        if (wrap) state_d = STOP;
      end
      STOP: begin
        if (at_vote) begin
          if (!vote) ferr_d = 1'b1;
          if (bit_q == LAST_STOP) begin
            done    = 1'b1;
            state_d = IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A frame completing while the previous word is still unaccepted is dropped.
    if (done) begin
      if (!valid_q || bus.rx_ready) begin
        data_d   = shift_q;
        perr_o_d = perr_q;
        ferr_o_d = ferr_q | ~vote;
        valid_d  = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (valid_q && bus.rx_ready) begin
      valid_d = 1'b0;
    end
  end

  assign bus.rx_data    = data_q;
  assign bus.rx_valid   = valid_q;
  assign bus.parity_err = perr_o_q;
  assign bus.frame_err  = ferr_o_q;
  assign bus.overrun    = ovr_q;
  assign bus.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: three receivers (8N1, 8E1, 8O2) fed by bit-level
// serial drivers; accepted words are collected and compared with the words
// the bench meant to send.
module tb_uart_rx_param;
  localparam int CLK_DIV = 16;

  typedef struct packed {
    logic [7:0] d;
    logic       pe;
    logic       fe;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic line [3];
  logic rdy  [3];
  int   ovr  [3];
  rec_t got_q [3][$];
  rec_t exp_q [3][$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  uart_rx_param_if #(.DATA_BITS(8)) ia ();
  uart_rx_param_if #(.DATA_BITS(8)) ib ();
  uart_rx_param_if #(.DATA_BITS(8)) ic ();

  assign ia.uart_rx = line[0];
  assign ib.uart_rx = line[1];
  assign ic.uart_rx = line[2];
  assign ia.rx_ready = rdy[0];
  assign ib.rx_ready = rdy[1];
  assign ic.rx_ready = rdy[2];

  uart_rx_param #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1))
    dut_a (.clk(clk), .rst(rst), .bus(ia));
  uart_rx_param #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1))
    dut_b (.clk(clk), .rst(rst), .bus(ib));
  uart_rx_param #(.CLK_DIV(CLK_DIV), .DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(2))
    dut_c (.clk(clk), .rst(rst), .bus(ic));

  // Collect every word the sink accepts and every overrun pulse.
  always @(negedge clk) begin
    if (ia.rx_valid && rdy[0]) got_q[0].push_back(rec_t'{ia.rx_data, ia.parity_err, ia.frame_err});
    if (ib.rx_valid && rdy[1]) got_q[1].push_back(rec_t'{ib.rx_data, ib.parity_err, ib.frame_err});
    if (ic.rx_valid && rdy[2]) got_q[2].push_back(rec_t'{ic.rx_data, ic.parity_err, ic.frame_err});
    if (ia.overrun) ovr[0]++;
    if (ib.overrun) ovr[1]++;
    if (ic.overrun) ovr[2]++;
  end

  function automatic bit has_par(input int d);
    return d != 0;
  endfunction
  function automatic bit par_odd(input int d);
    return d == 2;
  endfunction
  function automatic int n_stop(input int d);
    return (d == 2) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic hold(input int d, input logic v, input int n);
    line[d] = v;
    repeat (n) @(negedge clk);
  endtask

  // Drive one frame; the parity bit is the correct one unless par_flip is set.
  // After a low final stop bit the line is returned high so the next start is an edge.
  task automatic send_frame(input int d, input logic [7:0] data, input bit par_flip,
                            input logic [1:0] stop_val);
    logic pbit;
    pbit = (^data) ^ par_odd(d) ^ par_flip;
    hold(d, 1'b0, CLK_DIV);
    for (int i = 0; i < 8; i++) hold(d, data[i], CLK_DIV);
    if (has_par(d)) hold(d, pbit, CLK_DIV);
    for (int s = 0; s < n_stop(d); s++) hold(d, stop_val[s], CLK_DIV);
    if (stop_val[n_stop(d)-1] == 1'b0) hold(d, 1'b1, CLK_DIV);
  endtask

  // Reference: the word is the data sent; a parity error exactly when the
  // parity bit was corrupted; a frame error when any checked stop bit was low.
  task automatic send_exp(input int d, input logic [7:0] data, input bit par_flip,
                          input logic [1:0] stop_val);
    rec_t e;
    e.d  = data;
    e.pe = has_par(d) && par_flip;
    e.fe = (stop_val[0] == 1'b0) || (n_stop(d) == 2 && stop_val[1] == 1'b0);
    exp_q[d].push_back(e);
    send_frame(d, data, par_flip, stop_val);
  endtask

  task automatic check_words(input int d, input string tag);
    int   t;
    rec_t g, e;
    t = 0;
    while (got_q[d].size() < exp_q[d].size() && t < 20000) begin
      @(negedge clk);
      t++;
    end
    chk({tag, "_count"}, got_q[d].size(), exp_q[d].size());
    while (got_q[d].size() > 0 && exp_q[d].size() > 0) begin
      g = got_q[d].pop_front();
      e = exp_q[d].pop_front();
      chk({tag, "_data"}, g.d, e.d);
      chk({tag, "_perr"}, g.pe, e.pe);
      chk({tag, "_ferr"}, g.fe, e.fe);
    end
    got_q[d].delete();
    exp_q[d].delete();
  endtask

  initial begin
    logic [7:0] rd;
    logic [1:0] rs;
    bit         rf;
    int         t;
    for (int i = 0; i < 3; i++) begin
      line[i] = 1'b1;
      rdy[i]  = 1'b1;
      ovr[i]  = 0;
    end

    // Reset values, before any clock edge.
    #2;
    chk("rst_valid", ia.rx_valid, 0);
    chk("rst_data", ia.rx_data, 0);
    chk("rst_busy", ia.busy, 0);
    chk("rst_flags", {ib.parity_err, ic.frame_err, ic.overrun}, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // 8N1 back-to-back frames.
    send_exp(0, 8'h55, 0, 2'b11);
    send_exp(0, 8'hA3, 0, 2'b11);
    check_words(0, "a_b2b");

    // Random 8N1 frames, some with a low stop bit.
    for (int n = 0; n < 8; n++) begin
      rd = 8'($urandom_range(0, 255));
      rs = ($urandom_range(0, 3) == 0) ? 2'b10 : 2'b11;
      send_exp(0, rd, 0, rs);
    end
    check_words(0, "a_rand");
    chk("a_no_overrun", ovr[0], 0);

    // Short start glitch is rejected.
    line[0] = 1'b0;
    repeat (4) @(negedge clk);
    line[0] = 1'b1;
    repeat (2) @(negedge clk);
    chk("glitch_busy_hi", ia.busy, 1);
    repeat (CLK_DIV - 2) @(negedge clk);
    chk("glitch_busy_lo", ia.busy, 0);
    chk("glitch_no_word", got_q[0].size(), 0);

    // Backpressure: second frame dropped with a single overrun pulse.
    rdy[0] = 1'b0;
    send_frame(0, 8'h11, 0, 2'b11);
    send_frame(0, 8'h22, 0, 2'b11);
    repeat (CLK_DIV) @(negedge clk);
    chk("ovr_valid", ia.rx_valid, 1);
    chk("ovr_data", ia.rx_data, 8'h11);
    chk("ovr_pulses", ovr[0], 1);
    @(posedge clk);
    #1 rdy[0] = 1'b1;
    @(posedge clk);
    #1;
    chk("ovr_accept_fall", ia.rx_valid, 0);
    chk("ovr_data_kept", ia.rx_data, 8'h11);
    exp_q[0].push_back(rec_t'{8'h11, 1'b0, 1'b0});
    check_words(0, "ovr_word");

    // Async reset mid-frame with a word still pending.
    @(negedge clk);
    rdy[0] = 1'b0;
    send_frame(0, 8'h77, 0, 2'b11);
    hold(0, 1'b0, CLK_DIV);
    hold(0, 1'b0, 2 * CLK_DIV);
    line[0] = 1'b1;
    repeat (5) @(negedge clk);
    chk("pre_rst_busy", ia.busy, 1);
    chk("pre_rst_valid", ia.rx_valid, 1);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_valid", ia.rx_valid, 0);
    chk("async_rst_data", ia.rx_data, 0);
    chk("async_rst_busy", ia.busy, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    rdy[0] = 1'b1;
    got_q[0].delete();
    repeat (2 * CLK_DIV) @(negedge clk);
    send_exp(0, 8'h5A, 0, 2'b11);
    check_words(0, "post_rst");

    // Even parity: corrupted then correct parity bit, then random corruptions.
    send_exp(1, 8'h07, 1, 2'b11);
    send_exp(1, 8'h07, 0, 2'b11);
    check_words(1, "par_07");
    for (int n = 0; n < 8; n++) begin
      rd = 8'($urandom_range(0, 255));
      rf = ($urandom_range(0, 2) == 0);
      send_exp(1, rd, rf, 2'b11);
    end
    check_words(1, "par_rand");

    // Odd parity, two stop bits: second stop low, random stop/parity faults.
    send_exp(2, 8'h3C, 0, 2'b01);
    check_words(2, "stop2_low");
    for (int n = 0; n < 8; n++) begin
      rd = 8'($urandom_range(0, 255));
      rf = ($urandom_range(0, 3) == 0);
      rs = ($urandom_range(0, 2) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      send_exp(2, rd, rf, rs);
    end
    check_words(2, "c_rand");

    // Break: 20 bit times low gives one zero word (its parity bit is also wrong).
    hold(2, 1'b0, 20 * CLK_DIV);
    chk("break_one_word", got_q[2].size(), 1);
    exp_q[2].push_back(rec_t'{8'h00, 1'b1, 1'b1});
    hold(2, 1'b1, 2 * CLK_DIV);
    check_words(2, "break");
    send_exp(2, 8'h81, 0, 2'b11);
    check_words(2, "after_break");

    // Nothing spurious anywhere by the end.
    t = 0;
    while (t < 2 * CLK_DIV) begin
      @(negedge clk);
      t++;
    end
    chk("end_idle_a", ia.busy, 0);
    chk("end_no_ovr_bc", ovr[1] + ovr[2], 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
